// File: rtl/memory_arbiter_pkg.sv
// Shared FSM encoding and width helpers for the memory arbiter and its
// winner-selection sub-module.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  function automatic int addr_width(input int mem_size);
    return (mem_size > 1) ? $clog2(mem_size) : 1;
  endfunction

  function automatic int token_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter.sv
// Combinational winner selection: round-robin from ptr, or lowest index first
// when PRIO_MODE is 1.
module rr_arbiter #(
  parameter int N_CH      = 2,
  parameter int PRIO_MODE = 0,
  parameter int TW        = 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [TW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [TW-1:0]   grant_idx,
  output logic            grant_valid
);

  int start;
  int idx;

  // Scan N_CH positions beginning at the start point, wrapping past the top.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    start       = (PRIO_MODE == 1) ? 0 : int'(ptr);
    idx         = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (start + k) % N_CH;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = TW'(idx);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Multi-channel single-port memory arbiter: one transaction at a time,
// IDLE -> ISSUE -> (WAIT) -> RESP, with every output driven from a register.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter  int N_CH      = 2,
  parameter  int MEM_WIDTH = 32,
  parameter  int MEM_SIZE  = 256,
  parameter  int PRIO_MODE = 0,
  localparam int AW        = addr_width(MEM_SIZE),
  localparam int TW        = token_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH-1:0]        ch_we,
  input  logic [N_CH*AW-1:0]     ch_addr,
  input  logic [N_CH*MEM_WIDTH-1:0] ch_wdata,
  output logic [N_CH-1:0]        ch_ack,
  output logic [MEM_WIDTH-1:0]   ch_rdata,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_read_en,
  output logic                   mem_write_en,
  output logic [MEM_WIDTH-1:0]   mem_write_val,
  input  logic [MEM_WIDTH-1:0]   mem_read_val,
  output logic [TW-1:0]          token,
  output logic                   busy
);

  arb_state_t state, state_nxt;
  logic [TW-1:0] ptr, ptr_nxt, token_nxt;
  logic lat_we, lat_we_nxt;
  logic [N_CH-1:0] grant, ack_nxt;
  logic [TW-1:0] grant_idx;
  logic grant_valid;
  logic win_we, rd_nxt, wr_nxt, busy_nxt;
  logic [AW-1:0] win_addr, addr_nxt;
  logic [MEM_WIDTH-1:0] win_wdata, wval_nxt, rdata_nxt;

  rr_arbiter #(
    .N_CH      (N_CH),
    .PRIO_MODE (PRIO_MODE),
    .TW        (TW)
  ) u_rr_arbiter (
    .req         (ch_req),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        win_we    = ch_we[i];
        win_addr  = ch_addr[i*AW +: AW];
        win_wdata = ch_wdata[i*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= '0;
      token         <= '0;
      lat_we        <= 1'b0;
      ch_ack        <= '0;
      ch_rdata      <= '0;
      mem_addr      <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      token         <= token_nxt;
      lat_we        <= lat_we_nxt;
      ch_ack        <= ack_nxt;
      ch_rdata      <= rdata_nxt;
      mem_addr      <= addr_nxt;
      mem_read_en   <= rd_nxt;
      mem_write_en  <= wr_nxt;
      mem_write_val <= wval_nxt;
      busy          <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed one cycle early so each register lines up with the
  // state it belongs to (strobes during ISSUE, ack during RESP).
  always_comb begin
    ptr_nxt    = ptr;
    token_nxt  = token;
    lat_we_nxt = lat_we;
    addr_nxt   = mem_addr;
    wval_nxt   = mem_write_val;
    rdata_nxt  = ch_rdata;
    rd_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    ack_nxt    = '0;
    busy_nxt   = (state_nxt != IDLE);
    if (state == IDLE && grant_valid) begin
      ptr_nxt    = (grant_idx == TW'(N_CH - 1)) ? '0 : grant_idx + TW'(1);
      token_nxt  = grant_idx;
      lat_we_nxt = win_we;
      addr_nxt   = win_addr;
      wval_nxt   = win_wdata;
      rd_nxt     = !win_we;
      wr_nxt     = win_we;
    end
    if (state == WAIT) rdata_nxt = mem_read_val;
    for (int i = 0; i < N_CH; i++) begin
      ack_nxt[i] = (state_nxt == RESP) && (int'(token) == i);
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed cycle checks on a 2-channel instance and
// a scoreboarded random run on 4-channel round-robin and fixed-priority ones.
module tb_memory_arbiter;

  localparam int MW = 32;
  localparam int AW = 8;

  typedef struct {
    int          ch;
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  exp_t rr_q[$];
  logic [31:0] ref_mem [256];
  int model_ptr = 0;
  logic [31:0] rr_last_rdata = 32'h0;

  logic main_rst, two_rst;

  logic [1:0]      two_req, two_we, two_ack;
  logic [2*AW-1:0] two_addr;
  logic [2*MW-1:0] two_wdata;
  logic [MW-1:0]   two_rdata, two_wval, two_rval;
  logic [AW-1:0]   two_maddr;
  logic            two_rd, two_wr, two_busy, two_token;
  logic [MW-1:0]   two_mem [256];

  logic [3:0]      rr_req, rr_we, rr_ack;
  logic [4*AW-1:0] rr_addr;
  logic [4*MW-1:0] rr_wdata;
  logic [MW-1:0]   rr_rdata, rr_wval, rr_rval;
  logic [AW-1:0]   rr_maddr;
  logic            rr_rd, rr_wr, rr_busy;
  logic [1:0]      rr_token;
  logic [MW-1:0]   rr_mem [256];

  logic [3:0]      fp_req, fp_we, fp_ack;
  logic [4*AW-1:0] fp_addr;
  logic [4*MW-1:0] fp_wdata;
  logic [MW-1:0]   fp_rdata, fp_wval, fp_rval;
  logic [AW-1:0]   fp_maddr;
  logic            fp_rd, fp_wr, fp_busy;
  logic [1:0]      fp_token;

  assign fp_rval = 32'hC0FFEE00;

  memory_arbiter #(.N_CH(2), .MEM_WIDTH(MW), .MEM_SIZE(256), .PRIO_MODE(0)) u_two (
    .clk(clk), .reset(two_rst), .ch_req(two_req), .ch_we(two_we), .ch_addr(two_addr),
    .ch_wdata(two_wdata), .ch_ack(two_ack), .ch_rdata(two_rdata), .mem_addr(two_maddr),
    .mem_read_en(two_rd), .mem_write_en(two_wr), .mem_write_val(two_wval),
    .mem_read_val(two_rval), .token(two_token), .busy(two_busy)
  );

  memory_arbiter #(.N_CH(4), .MEM_WIDTH(MW), .MEM_SIZE(256), .PRIO_MODE(0)) u_rr (
    .clk(clk), .reset(main_rst), .ch_req(rr_req), .ch_we(rr_we), .ch_addr(rr_addr),
    .ch_wdata(rr_wdata), .ch_ack(rr_ack), .ch_rdata(rr_rdata), .mem_addr(rr_maddr),
    .mem_read_en(rr_rd), .mem_write_en(rr_wr), .mem_write_val(rr_wval),
    .mem_read_val(rr_rval), .token(rr_token), .busy(rr_busy)
  );

  memory_arbiter #(.N_CH(4), .MEM_WIDTH(MW), .MEM_SIZE(256), .PRIO_MODE(1)) u_fp (
    .clk(clk), .reset(main_rst), .ch_req(fp_req), .ch_we(fp_we), .ch_addr(fp_addr),
    .ch_wdata(fp_wdata), .ch_ack(fp_ack), .ch_rdata(fp_rdata), .mem_addr(fp_maddr),
    .mem_read_en(fp_rd), .mem_write_en(fp_wr), .mem_write_val(fp_wval),
    .mem_read_val(fp_rval), .token(fp_token), .busy(fp_busy)
  );

  function automatic logic [31:0] mem_init(input int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (two_wr) two_mem[two_maddr] <= two_wval;
    if (two_rd) two_rval <= two_mem[two_maddr];
  end

  // The round-robin memory is preloaded while reset is low so the model can
  // predict reads of never-written words.
  always @(posedge clk) begin
    if (!main_rst) begin
      for (int i = 0; i < 256; i++) rr_mem[i] <= mem_init(i);
    end else begin
      if (rr_wr) rr_mem[rr_maddr] <= rr_wval;
      if (rr_rd) rr_rval <= rr_mem[rr_maddr];
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : rr_monitor
    exp_t e;
    if (rr_ack != 4'b0) begin
      if (rr_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL rr_unexpected_ack: got 0x%0h, expected no ack", rr_ack);
      end else begin
        e = rr_q.pop_front();
        check_output("rr_ack_channel", 32'(rr_ack), 32'(1) << e.ch);
        check_output("rr_token", 32'(rr_token), 32'(e.ch));
        if (e.is_read) begin
          check_output("rr_read_data", rr_rdata, e.data);
          rr_last_rdata = e.data;
        end else begin
          check_output("rr_rdata_held_on_write", rr_rdata, rr_last_rdata);
        end
      end
    end
  end

  task automatic check_reset_values();
    check_output("rst_two_busy", 32'(two_busy), 32'd0);
    check_output("rst_two_ack", 32'(two_ack), 32'd0);
    check_output("rst_two_token", 32'(two_token), 32'd0);
    check_output("rst_rr_strobes", {30'd0, rr_rd, rr_wr}, 32'd0);
    check_output("rst_rr_addr", 32'(rr_maddr), 32'd0);
    check_output("rst_rr_wval", rr_wval, 32'd0);
    check_output("rst_rr_rdata", rr_rdata, 32'd0);
    check_output("rst_rr_token", 32'(rr_token), 32'd0);
    check_output("rst_rr_busy", 32'(rr_busy), 32'd0);
  endtask

  task automatic apply_stimulus_two();
    @(negedge clk);
    two_req = 2'b10; two_we = 2'b10;
    two_addr = {8'h10, 8'h00}; two_wdata = {32'hDEADBEEF, 32'h0};
    tick();
    check_output("wr_strobe_c1", 32'(two_wr), 32'd1);
    check_output("wr_read_strobe_c1", 32'(two_rd), 32'd0);
    check_output("wr_addr_c1", 32'(two_maddr), 32'h10);
    check_output("wr_val_c1", two_wval, 32'hDEADBEEF);
    check_output("wr_busy_c1", 32'(two_busy), 32'd1);
    check_output("wr_token_c1", 32'(two_token), 32'd1);
    tick();
    check_output("wr_strobe_c2", 32'(two_wr), 32'd0);
    check_output("wr_ack_c2", 32'(two_ack), 32'h2);
    two_req = 2'b00;
    tick();
    check_output("wr_ack_c3", 32'(two_ack), 32'd0);
    check_output("wr_busy_c3", 32'(two_busy), 32'd0);

    two_req = 2'b01; two_we = 2'b00; two_addr = {8'h00, 8'h10};
    tick();
    check_output("rd_strobe_c1", 32'(two_rd), 32'd1);
    check_output("rd_addr_c1", 32'(two_maddr), 32'h10);
    check_output("rd_token_c1", 32'(two_token), 32'd0);
    tick();
    check_output("rd_strobe_c2", 32'(two_rd), 32'd0);
    check_output("rd_ack_c2", 32'(two_ack), 32'd0);
    tick();
    check_output("rd_ack_c3", 32'(two_ack), 32'h1);
    check_output("rd_data_c3", two_rdata, 32'hDEADBEEF);
    two_req = 2'b00;
    tick();
    check_output("rd_ack_c4", 32'(two_ack), 32'd0);

    two_req = 2'b01; two_we = 2'b01; two_addr = {8'h00, 8'h20};
    two_wdata = {32'h0, 32'h12345678};
    tick();
    tick();
    check_output("wr2_ack", 32'(two_ack), 32'h1);
    check_output("wr2_rdata_held", two_rdata, 32'hDEADBEEF);
    two_req = 2'b00;
    tick();

    // Request withdrawn during ISSUE with a changed address: the latched read completes.
    two_req = 2'b01; two_we = 2'b00; two_addr = {8'h00, 8'h20};
    tick();
    check_output("drop_strobe_c1", 32'(two_rd), 32'd1);
    two_req = 2'b00; two_addr = {8'h00, 8'h33};
    tick();
    tick();
    check_output("drop_ack_c3", 32'(two_ack), 32'h1);
    check_output("drop_data_c3", two_rdata, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("drop_no_regrant", {29'd0, two_busy, two_rd, two_wr}, 32'd0);
    end

    // Reset during WAIT of a ch0 read; ptr is 1 at that point.
    two_req = 2'b01; two_addr = {8'h00, 8'h10};
    tick();
    tick();
    two_rst = 1'b0;
    #1;
    check_output("rstw_read_en", 32'(two_rd), 32'd0);
    check_output("rstw_busy", 32'(two_busy), 32'd0);
    check_output("rstw_ack", 32'(two_ack), 32'd0);
    check_output("rstw_token", 32'(two_token), 32'd0);
    tick();
    check_output("rstw_no_ack", 32'(two_ack), 32'd0);
    two_req = 2'b11; two_addr = {8'h10, 8'h10};
    @(negedge clk);
    two_rst = 1'b1;
    #1;
    check_output("rel_token", 32'(two_token), 32'd0);
    tick();
    check_output("rel_grant_ch0", 32'(two_token), 32'd0);
    check_output("rel_read_en", 32'(two_rd), 32'd1);
    tick();
    tick();
    check_output("rel_ack0", 32'(two_ack), 32'h1);
    check_output("rel_data0", two_rdata, 32'hDEADBEEF);
    two_req = 2'b10;
    tick();
    tick();
    check_output("rel_grant_ch1", 32'(two_token), 32'd1);
    tick();
    tick();
    check_output("rel_ack1", 32'(two_ack), 32'h2);
    two_req = 2'b00;
    tick();
  endtask

  // Four reads held continuously: grants rotate 0,1,2,3 then back to 0.
  task automatic apply_stimulus_rr_rotation();
    exp_t e;
    int seen;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      rr_we[c] = 1'b0;
      rr_addr[c*AW +: AW] = 8'(8'h40 + c);
    end
    for (int g = 0; g < 5; g++) begin
      e.ch = g % 4;
      e.is_read = 1'b1;
      e.data = ref_mem[8'h40 + (g % 4)];
      rr_q.push_back(e);
    end
    rr_req = 4'b1111;
    seen = 0;
    for (int b = 0; b < 100 && seen < 5; b++) begin
      @(negedge clk);
      if (rr_ack != 4'b0) seen++;
    end
    rr_req = 4'b0000;
    check_output("rot_ack_count", 32'(seen), 32'd5);
    model_ptr = 1;
  endtask

  // Each round raises a random set of requests together; the model orders the
  // grants by scanning cyclically from its pointer and plays the accesses
  // against its own copy of memory.
  task automatic apply_stimulus_rr_random(input int rounds);
    logic [3:0] mask, pending;
    exp_t e;
    int w, c, a;
    for (int r = 0; r < rounds; r++) begin
      mask = 4'($urandom_range(1, 15));
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        rr_we[k] = 1'($urandom_range(0, 1));
        rr_addr[k*AW +: AW] = 8'($urandom_range(0, 15));
        rr_wdata[k*MW +: MW] = $urandom;
      end
      pending = mask;
      while (pending != 4'b0) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          c = (model_ptr + k) % 4;
          if (w < 0 && pending[c]) w = c;
        end
        a = int'(rr_addr[w*AW +: AW]);
        e.ch = w;
        e.is_read = !rr_we[w];
        e.data = ref_mem[a];
        if (rr_we[w]) ref_mem[a] = rr_wdata[w*MW +: MW];
        rr_q.push_back(e);
        pending[w] = 1'b0;
        model_ptr = (w + 1) % 4;
      end
      rr_req = mask;
      for (int b = 0; b < 200 && rr_req != 4'b0; b++) begin
        @(negedge clk);
        rr_req = rr_req & ~rr_ack;
      end
      check_output("round_complete", 32'(rr_req), 32'd0);
      rr_req = 4'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic apply_stimulus_fp();
    int cnt;
    int b;
    @(negedge clk);
    fp_we = 4'b0000;
    fp_req = 4'b1100;
    cnt = 0;
    for (b = 0; b < 100 && cnt < 4; b++) begin
      @(negedge clk);
      if (fp_ack != 4'b0) begin
        check_output("fp_ack_is_ch2", 32'(fp_ack), 32'h4);
        check_output("fp_token_ch2", 32'(fp_token), 32'd2);
        cnt++;
      end
    end
    check_output("fp_ch2_grants", 32'(cnt), 32'd4);
    fp_req = 4'b1000;
    cnt = 0;
    for (b = 0; b < 50 && cnt < 1; b++) begin
      @(negedge clk);
      if (fp_ack != 4'b0) begin
        check_output("fp_ack_is_ch3", 32'(fp_ack), 32'h8);
        cnt++;
      end
    end
    check_output("fp_ch3_after_drop", 32'(cnt), 32'd1);
    fp_req = 4'b0000;
  endtask

  initial begin
    main_rst = 1'b1; two_rst = 1'b1;
    two_req = '0; two_we = '0; two_addr = '0; two_wdata = '0;
    rr_req = '0; rr_we = '0; rr_addr = '0; rr_wdata = '0;
    fp_req = '0; fp_we = '0; fp_addr = '0; fp_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
    #2;
    main_rst = 1'b0; two_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    main_rst = 1'b1; two_rst = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus_two();
    apply_stimulus_rr_rotation();
    apply_stimulus_rr_random(60);
    apply_stimulus_fp();
    repeat (4) @(negedge clk);
    check_output("scoreboard_drained", 32'(rr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
